rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//  Parametrised N-channel stream multiplexer with a registered output stage and valid/ready handshakes.
//  Selection is either driven by the sel input or by an internal round-robin arbiter.
//  Sits between several producer streams and one consumer; it is the clocked successor to the 4:1 sel mux.
// PARAMETERS
//  NCH    4  number of input channels (>=2)
//  WIDTH  4  data width per channel
//  MODE   0  0 = sel-driven select, 1 = round-robin arbitration (sel ignored)
//  SEL_W  $clog2(NCH)  localparam, width of sel/out_ch
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  sel       in   SEL_W      channel select (MODE 0 only)
//  in_data   in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_valid  in   NCH        per-channel valid
//  in_ready  out  NCH        per-channel ready (combinational)
//  out_data  out  WIDTH      registered data
//  out_ch    out  SEL_W      channel index of out_data
//  out_valid out  1          output holds a beat
//  out_ready in   1          consumer accepts
//  in_last   in   NCH        end-of-packet marker (only with RR_LOCK_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr pointer last=NCH-1, lock cleared.
//  - load = in_valid[g] && (!out_valid || out_ready); g = current grant.
//  - in_ready[i] = (i==g) && (!out_valid || out_ready); all other in_ready bits 0.
//  - Transfer on input i when in_valid[i] && in_ready[i]; on load: out_data<=in_data[g], out_ch<=g, out_valid<=1.
//  - Output: out_valid && out_ready with no load -> out_valid<=0; data/ch hold their value.
//  - Latency 1 cycle input->output; full throughput (1 beat/cycle) when out_ready held 1.
//  - Stall: out_valid && !out_ready -> out_data/out_ch stable, in_ready all 0.
//  - MODE 0: g = sel; sel >= NCH (non-power-of-2 NCH) -> no grant, in_ready all 0 (no default channel).
//  - MODE 1: g = first valid channel searching last+1, last+2, ... mod NCH; last<=g only on a transfer.
//    No valid channel -> no grant, last unchanged. Wrap NCH-1 -> 0 is required.
//  - sel or valid changes while stalled have no effect on the held output.
//  - Reset asserted mid-transfer: pending output beat is dropped, no partial state remains.
//  - No combinational path from out_ready to out_data; out_ready->in_ready path is permitted.
// CONFIGURATION
//  RR_LOCK_EN defined: MODE 1 gains states ARB/LOCK.
//    ARB: on a transfer from g with in_last[g]=0 -> LOCK(g). LOCK: grant fixed to g,
//    other channels get no in_ready; a transfer with in_last[g]=1 -> ARB (last<=g). Reset -> ARB.
//    MODE 0 ignores in_last.
//  RR_LOCK_EN undefined: in_last port absent; arbitration is per beat.
// TESTING (NCH=4, WIDTH=4, in_data ch0..3 = 1,2,3,4)
//  1 MODE0, all valid, out_ready=1, sel 0,1,2,3 each 2 cycles -> out_data 1,2,3,4 one cycle after each sel.
//  2 MODE1, all valid continuously, out_ready=1 -> out_ch 0,1,2,3,0,1 back-to-back, out_valid stays 1.
//  3 MODE1, only ch1 and ch3 valid -> out_ch 1,3,1,3; wrap from 3 to 1 via 0/2 skipped.
//  4 out_ready=0 for 5 cycles after first beat -> out_data stays 1, in_ready=0000; on release next beat follows.
//  5 rst_n pulsed low mid-stream (async, off clock edge) -> out_valid=0 immediately; after release first grant is ch0.
//  6 RR_LOCK_EN, ch0 sends 3 beats in_last=0,0,1 while ch1 valid -> out_ch 0,0,0 then 1.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel valid/ready stream mux, sel-driven or round-robin, registered output
// Optional: define RR_LOCK_EN to hold round-robin grant on one channel until its in_last beat.
module rr_stream_mux #(
    parameter int NCH   = 4,
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
`ifdef RR_LOCK_EN
    input  logic [NCH-1:0]       in_last,
`endif
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic [SEL_W-1:0] r_last;

    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_search;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    logic             w_gvld;
    logic             w_can;
    logic             w_load;
    logic [WIDTH-1:0] w_data;

`ifdef RR_LOCK_EN
    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_lock_ch;
`endif

    // Round-robin search starts just after the last channel that transferred.
    always_comb begin
        w_search = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = SEL_W'((int'(r_last) + k) % NCH);
            if (!w_found && in_valid[w_idx]) begin
                w_found  = 1'b1;
                w_search = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = sel;
        w_gvld  = (int'(sel) < NCH);
        if (MODE == 1) begin
            w_grant = w_search;
            w_gvld  = w_found;
`ifdef RR_LOCK_EN
            if (r_state == ST_LOCK) begin
                w_grant = r_lock_ch;
                w_gvld  = 1'b1;
            end
`endif
        end
    end

    assign w_can  = !r_valid || out_ready;
    assign w_load = w_gvld && w_can && in_valid[w_grant];
    assign w_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

    for (genvar i = 0; i < NCH; i++) begin : g_ready
        assign in_ready[i] = w_gvld && w_can && (w_grant == SEL_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_last  <= SEL_W'(NCH - 1);
        end else begin
            if (w_load) begin
                r_data  <= w_data;
                r_ch    <= w_grant;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (MODE == 1 && w_load) begin
                r_last <= w_grant;
            end
        end
    end

`ifdef RR_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ARB;
            r_lock_ch <= '0;
        end else if (MODE == 1 && w_load) begin
            case (r_state)
                ST_ARB: begin
                    if (!in_last[w_grant]) begin
                        r_state   <= ST_LOCK;
                        r_lock_ch <= w_grant;
                    end
                end
                default: begin
                    if (in_last[w_grant]) begin
                        r_state <= ST_ARB;
                    end
                end
            endcase
        end
    end
`endif

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - directed and randomized checks of rr_stream_mux in sel and round-robin modes
module tb_rr_stream_mux;
    localparam int NCH   = 4;
    localparam int WIDTH = 4;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [SEL_W-1:0]     sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       v0, v1, rdy0, rdy1, last0, last1;
    logic                 ordy0, ordy1, ov0, ov1;
    logic [WIDTH-1:0]     od0, od1;
    logic [SEL_W-1:0]     oc0, oc1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_ov0, m_od0, m_oc0;
    int m_ov1, m_od1, m_oc1, m_last, m_lock, m_lock_ch;

    rr_stream_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(v0),
`ifdef RR_LOCK_EN
        .in_last(last0),
`endif
        .in_ready(rdy0), .out_data(od0), .out_ch(oc0), .out_valid(ov0), .out_ready(ordy0)
    );

    rr_stream_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(v1),
`ifdef RR_LOCK_EN
        .in_last(last1),
`endif
        .in_ready(rdy1), .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(ordy1)
    );

    function automatic int rr_grant();
        if (m_lock != 0) return m_lock_ch;
        for (int k = 1; k <= NCH; k++) begin
            if (v1[(m_last + k) % NCH]) return (m_last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ov0 = 0; m_od0 = 0; m_oc0 = 0;
        m_ov1 = 0; m_od1 = 0; m_oc1 = 0;
        m_last = NCH - 1; m_lock = 0; m_lock_ch = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; v0 = '0; v1 = '0; last0 = '0; last1 = '0;
        ordy0 = 1'b0; ordy1 = 1'b0; sel = '0; in_data = 16'h4321;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({ov0, oc0, od0} !== 7'd0) begin
            bad++; $display("FAIL reset_sel: got v/ch/data=%b/%0d/%0d want 0/0/0", ov0, oc0, od0);
        end
        total++;
        if ({ov1, oc1, od1} !== 7'd0) begin
            bad++; $display("FAIL reset_rr: got v/ch/data=%b/%0d/%0d want 0/0/0", ov1, oc1, od1);
        end
        total++;
        if (rdy1 !== 4'b0000) begin
            bad++; $display("FAIL reset_rr_ready: got %b want 0000", rdy1);
        end
    endtask

    task automatic test_sel_mode();
        do_reset();
        for (int s = 0; s < NCH; s++) begin
            for (int rep = 0; rep < 2; rep++) begin
                @(negedge clk);
                sel = SEL_W'(s); v0 = 4'b1111; ordy0 = 1'b1;
                @(posedge clk); #1;
                total++;
                if (!(ov0 === 1'b1 && oc0 === SEL_W'(s) && od0 === WIDTH'(s + 1))) begin
                    bad++; $display("FAIL sel_mode s=%0d: got v/ch/data=%b/%0d/%0d want 1/%0d/%0d", s, ov0, oc0, od0, s, s + 1);
                end
            end
        end
    endtask

    task automatic test_rr_all_valid();
        do_reset();
        @(negedge clk);
        v1 = 4'b1111; ordy1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if (!(ov1 === 1'b1 && oc1 === SEL_W'(k % NCH) && od1 === WIDTH'(k % NCH + 1))) begin
                bad++; $display("FAIL rr_all beat %0d: got v/ch/data=%b/%0d/%0d want 1/%0d/%0d", k, ov1, oc1, od1, k % NCH, k % NCH + 1);
            end
        end
    endtask

    task automatic test_rr_sparse();
        do_reset();
        @(negedge clk);
        v1 = 4'b1010; ordy1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if (!(ov1 === 1'b1 && oc1 === SEL_W'((k % 2 == 0) ? 1 : 3))) begin
                bad++; $display("FAIL rr_sparse beat %0d: got v/ch=%b/%0d want 1/%0d", k, ov1, oc1, (k % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        sel = 2'd0; v0 = 4'b1111; ordy0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        ordy0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            sel = SEL_W'($urandom_range(0, 3)); v0 = 4'($urandom);
            #1;
            total++;
            if (rdy0 !== 4'b0000) begin
                bad++; $display("FAIL stall_ready cyc %0d: got %b want 0000", k, rdy0);
            end
            @(posedge clk); #1;
            total++;
            if (!(ov0 === 1'b1 && od0 === 4'd1 && oc0 === 2'd0)) begin
                bad++; $display("FAIL stall_hold cyc %0d: got v/ch/data=%b/%0d/%0d want 1/0/1", k, ov0, oc0, od0);
            end
        end
        @(negedge clk);
        sel = 2'd1; v0 = 4'b1111; ordy0 = 1'b1;
        #1;
        total++;
        if (rdy0 !== 4'b0010) begin
            bad++; $display("FAIL stall_release_ready: got %b want 0010", rdy0);
        end
        @(posedge clk); #1;
        total++;
        if (!(ov0 === 1'b1 && od0 === 4'd2 && oc0 === 2'd1)) begin
            bad++; $display("FAIL stall_release_beat: got v/ch/data=%b/%0d/%0d want 1/1/2", ov0, oc0, od0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        v1 = 4'b1111; ordy1 = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov1, oc1, od1} !== 7'd0) begin
            bad++; $display("FAIL async_reset: got v/ch/data=%b/%0d/%0d want 0/0/0", ov1, oc1, od1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (!(ov1 === 1'b1 && oc1 === 2'd0 && od1 === 4'd1)) begin
            bad++; $display("FAIL async_reset_first: got v/ch/data=%b/%0d/%0d want 1/0/1", ov1, oc1, od1);
        end
    endtask

`ifdef RR_LOCK_EN
    task automatic test_lock();
        int exp_ch[4];
        exp_ch = '{0, 0, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v1 = (k < 3) ? 4'b0011 : 4'b0010;
            last1 = (k == 2) ? 4'b0011 : 4'b0010;
            ordy1 = 1'b1;
            @(posedge clk); #1;
            total++;
            if (!(ov1 === 1'b1 && oc1 === SEL_W'(exp_ch[k]))) begin
                bad++; $display("FAIL lock beat %0d: got v/ch=%b/%0d want 1/%0d", k, ov1, oc1, exp_ch[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int g, s, c;
        logic [3:0] e0, e1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            in_data = 16'($urandom);
            v0 = 4'($urandom); v1 = 4'($urandom);
            sel = SEL_W'($urandom_range(0, 3));
            last0 = 4'($urandom); last1 = 4'($urandom);
            ordy0 = ($urandom_range(0, 3) != 0);
            ordy1 = ($urandom_range(0, 3) != 0);
            #1;
            s = int'(sel);
            c = (m_ov0 == 0 || ordy0) ? 1 : 0;
            e0 = (c != 0) ? 4'(1 << s) : 4'b0000;
            g = rr_grant();
            c = (m_ov1 == 0 || ordy1) ? 1 : 0;
            e1 = (c != 0 && g >= 0) ? 4'(1 << g) : 4'b0000;
            total++;
            if (rdy0 !== e0) begin
                bad++; $display("FAIL rand_ready_sel n=%0d: got %b want %b", n, rdy0, e0);
            end
            total++;
            if (rdy1 !== e1) begin
                bad++; $display("FAIL rand_ready_rr n=%0d: got %b want %b", n, rdy1, e1);
            end
            if (e0[s] && v0[s]) begin
                m_ov0 = 1; m_od0 = int'(in_data[s*WIDTH +: WIDTH]); m_oc0 = s;
            end else if (ordy0) begin
                m_ov0 = 0;
            end
            if (g >= 0 && e1[g] && v1[g]) begin
                m_ov1 = 1; m_od1 = int'(in_data[g*WIDTH +: WIDTH]); m_oc1 = g;
                m_last = g;
`ifdef RR_LOCK_EN
                if (m_lock == 0 && !last1[g]) begin
                    m_lock = 1; m_lock_ch = g;
                end else if (m_lock != 0 && last1[g]) begin
                    m_lock = 0;
                end
`endif
            end else if (ordy1) begin
                m_ov1 = 0;
            end
            @(posedge clk); #1;
            total++;
            if (!(ov0 === 1'(m_ov0) && oc0 === SEL_W'(m_oc0) && od0 === WIDTH'(m_od0))) begin
                bad++; $display("FAIL rand_out_sel n=%0d: got v/ch/data=%b/%0d/%0d want %0d/%0d/%0d", n, ov0, oc0, od0, m_ov0, m_oc0, m_od0);
            end
            total++;
            if (!(ov1 === 1'(m_ov1) && oc1 === SEL_W'(m_oc1) && od1 === WIDTH'(m_od1))) begin
                bad++; $display("FAIL rand_out_rr n=%0d: got v/ch/data=%b/%0d/%0d want %0d/%0d/%0d", n, ov1, oc1, od1, m_ov1, m_oc1, m_od1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = '0; in_data = 16'h4321; v0 = '0; v1 = '0;
        last0 = '0; last1 = '0; ordy0 = 1'b0; ordy1 = 1'b0;
        model_reset();
        test_reset();
        test_sel_mode();
        test_rr_all_valid();
        test_rr_sparse();
        test_stall();
        test_async_reset();
`ifdef RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
